// File: rtl/dispatch_ctrl.sv
// ---------------------------------------------------------------------------
// dispatch_ctrl
//
// In-order dispatch scheduler sitting between instruction fetch and the
// decoder. Fetched (pc, instruction) pairs are buffered in a small circular
// queue. At most one entry per cycle is released to the decoder, and only
// when the ROB and the target station both have room. Loads and stores go
// to the LSB. Every other opcode goes to the RS. Each dispatch carries a
// ROB allocation pulse and the ROB tag that was offered in the same cycle.
// A mispredict clear empties the queue. The FSM then spends one ready
// cycle in FLUSH before it accepts fetches again.
//
// Ports
//   clk_in         clock, rising edge
//   rst_in         asynchronous active-low reset
//   rdy_in         global ready; 0 freezes all state (clear still acts)
//   clear          mispredict flush, sampled at the clock edge
//   if_valid       fetch offers an instruction
//   if_pc          pc of the offered instruction
//   if_inst        offered instruction word
//   if_ready       queue accepts this cycle (combinational)
//   rob_has_space  ROB can take one entry this cycle
//   rob_tag        tag the ROB will assign to its next entry
//   rs_has_space   RS has a free slot
//   lsb_has_space  LSB has a free slot
//   dec_valid      registered one-cycle pulse: dec_* hold a dispatched entry
//   dec_pc         pc of the dispatched instruction
//   dec_inst       dispatched instruction word
//   dec_tag        ROB tag captured at dispatch
//   dec_to_lsb     1 = route to LSB, 0 = route to RS
//   rob_alloc      registered pulse, coincident with dec_valid
//   stall_cnt      saturating count of cycles in which the head was blocked
// ---------------------------------------------------------------------------
module dispatch_ctrl #(
  parameter int IQ_DEPTH_LOG = 2,
  parameter int ROB_WIDTH    = 4
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 clear,
  input  logic                 if_valid,
  input  logic [31:0]          if_pc,
  input  logic [31:0]          if_inst,
  output logic                 if_ready,
  input  logic                 rob_has_space,
  input  logic [ROB_WIDTH-1:0] rob_tag,
  input  logic                 rs_has_space,
  input  logic                 lsb_has_space,
  output logic                 dec_valid,
  output logic [31:0]          dec_pc,
  output logic [31:0]          dec_inst,
  output logic [ROB_WIDTH-1:0] dec_tag,
  output logic                 dec_to_lsb,
  output logic                 rob_alloc,
  output logic [15:0]          stall_cnt
);

  localparam int DEPTH = 1 << IQ_DEPTH_LOG;

  localparam logic [IQ_DEPTH_LOG-1:0] PTR_ONE    = IQ_DEPTH_LOG'(1);
  localparam logic [IQ_DEPTH_LOG:0]   CNT_ONE    = (IQ_DEPTH_LOG + 1)'(1);
  localparam logic [IQ_DEPTH_LOG:0]   CNT_FULL   = (IQ_DEPTH_LOG + 1)'(DEPTH);
  localparam logic [6:0]              OPC_LOAD   = 7'b0000011;
  localparam logic [6:0]              OPC_STORE  = 7'b0100011;
  localparam logic [15:0]             STALL_SAT  = 16'hFFFF;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t                 r_state;
  state_t                 w_state_next;

  logic [IQ_DEPTH_LOG-1:0] r_head;
  logic [IQ_DEPTH_LOG-1:0] r_tail;
  logic [IQ_DEPTH_LOG:0]   r_count;

  logic [31:0]             r_pc_mem   [DEPTH];
  logic [31:0]             r_inst_mem [DEPTH];

  logic                    r_dec_valid;
  logic [31:0]             r_dec_pc;
  logic [31:0]             r_dec_inst;
  logic [ROB_WIDTH-1:0]    r_dec_tag;
  logic                    r_dec_to_lsb;
  logic                    r_rob_alloc;
  logic [15:0]             r_stall_cnt;

  // -------------------------------------------------------------------------
  // Head decode
  // -------------------------------------------------------------------------
  logic        w_empty;
  logic        w_full;
  logic [31:0] w_head_pc;
  logic [31:0] w_head_inst;
  logic        w_head_is_mem;
  logic        w_target_space;

  assign w_empty       = (r_count == '0);
  assign w_full        = (r_count == CNT_FULL);
  assign w_head_pc     = r_pc_mem[r_head];
  assign w_head_inst   = r_inst_mem[r_head];
  assign w_head_is_mem = (w_head_inst[6:0] == OPC_LOAD) ||
                         (w_head_inst[6:0] == OPC_STORE);
  // The head needs a ROB slot plus a slot in whichever station it targets.
  assign w_target_space = rob_has_space &&
                          (w_head_is_mem ? lsb_has_space : rs_has_space);

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state. clear wins over rdy_in. A clear that arrives while
  // already flushing re-arms FLUSH.
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    if (clear) begin
      w_state_next = ST_FLUSH;
    end else if (r_state == ST_FLUSH && rdy_in) begin
      w_state_next = ST_RUN;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: outputs and per-cycle strobes
  // -------------------------------------------------------------------------
  logic w_enq;
  logic w_dispatch;
  logic w_stall_inc;

  always_comb begin
    if_ready    = 1'b0;
    w_dispatch  = 1'b0;
    w_stall_inc = 1'b0;
    if (r_state == ST_RUN) begin
      // The full check ignores a same-cycle dequeue. This keeps if_ready
      // independent of the downstream space signals.
      if_ready    = rst_in && rdy_in && !w_full && !clear;
      w_dispatch  = rdy_in && !clear && !w_empty && w_target_space;
      // Any ready RUN cycle with a waiting head that does not go out.
      w_stall_inc = rdy_in && !w_empty && !w_dispatch;
    end
    w_enq = if_ready && if_valid;
  end

  // -------------------------------------------------------------------------
  // Queue storage. The head is read combinationally, so a freshly written
  // entry is only visible to the dispatch logic one cycle later.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_pc_mem[i]   <= '0;
        r_inst_mem[i] <= '0;
      end
    end else if (w_enq) begin
      r_pc_mem[r_tail]   <= if_pc;
      r_inst_mem[r_tail] <= if_inst;
    end
  end

  // -------------------------------------------------------------------------
  // Queue pointers and occupancy. w_enq and w_dispatch are already gated
  // by rdy_in, clear and state, so a paused cycle leaves these untouched.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (clear) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) begin
        r_tail <= r_tail + PTR_ONE;
      end
      if (w_dispatch) begin
        r_head <= r_head + PTR_ONE;
      end
      case ({w_enq, w_dispatch})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Decoder-facing registers. The payload fields keep their last value
  // between dispatches. Only the valid/alloc strobes drop back to 0.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_dec_valid  <= 1'b0;
      r_rob_alloc  <= 1'b0;
      r_dec_pc     <= '0;
      r_dec_inst   <= '0;
      r_dec_tag    <= '0;
      r_dec_to_lsb <= 1'b0;
    end else begin
      r_dec_valid <= w_dispatch;
      r_rob_alloc <= w_dispatch;
      if (w_dispatch) begin
        r_dec_pc     <= w_head_pc;
        r_dec_inst   <= w_head_inst;
        r_dec_tag    <= rob_tag;
        r_dec_to_lsb <= w_head_is_mem;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stall counter. It saturates and is never cleared by a flush.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_stall_cnt <= '0;
    end else if (w_stall_inc && (r_stall_cnt != STALL_SAT)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign dec_valid  = r_dec_valid;
  assign dec_pc     = r_dec_pc;
  assign dec_inst   = r_dec_inst;
  assign dec_tag    = r_dec_tag;
  assign dec_to_lsb = r_dec_to_lsb;
  assign rob_alloc  = r_rob_alloc;
  assign stall_cnt  = r_stall_cnt;

endmodule

// File: tb/tb_dispatch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dispatch_ctrl
//
// Directed bench for dispatch_ctrl. A cycle-level reference model predicts
// each dispatch from the spec rules and pushes the expected decoder payload
// onto a scoreboard. The payload is popped and compared when dec_valid
// appears. Directed checks cover latency, ordering, backpressure, flush,
// pause and mid-cycle reset.
// ---------------------------------------------------------------------------
module tb_dispatch_ctrl;

  localparam logic [31:0] ADD_INST = 32'h002081B3;
  localparam logic [31:0] LW_INST  = 32'h0000A083;
  localparam logic [31:0] DROP_PC  = 32'hDEAD0000;

  logic        clk_in;
  logic        rst_in;
  logic        rdy_in;
  logic        clear;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_ready;
  logic        rob_has_space;
  logic [3:0]  rob_tag;
  logic        rs_has_space;
  logic        lsb_has_space;
  logic        dec_valid;
  logic [31:0] dec_pc;
  logic [31:0] dec_inst;
  logic [3:0]  dec_tag;
  logic        dec_to_lsb;
  logic        rob_alloc;
  logic [15:0] stall_cnt;

  dispatch_ctrl #(
    .IQ_DEPTH_LOG(2),
    .ROB_WIDTH   (4)
  ) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .rdy_in       (rdy_in),
    .clear        (clear),
    .if_valid     (if_valid),
    .if_pc        (if_pc),
    .if_inst      (if_inst),
    .if_ready     (if_ready),
    .rob_has_space(rob_has_space),
    .rob_tag      (rob_tag),
    .rs_has_space (rs_has_space),
    .lsb_has_space(lsb_has_space),
    .dec_valid    (dec_valid),
    .dec_pc       (dec_pc),
    .dec_inst     (dec_inst),
    .dec_tag      (dec_tag),
    .dec_to_lsb   (dec_to_lsb),
    .rob_alloc    (rob_alloc),
    .stall_cnt    (stall_cnt)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } mq_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [3:0]  tag;
    logic        lsb;
  } sb_t;

  mq_t         mq[$];        // model of the instruction queue
  sb_t         sb[$];        // expected decoder payloads
  logic [31:0] disp_pc[$];   // pcs seen on dec_pc
  int          disp_cyc[$];  // edge index of each dispatch
  int          acc_cyc[$];   // edge index of each accepted fetch
  logic        m_run;
  logic [15:0] m_stall;
  int          cyc;
  int          n_checks;
  int          n_errors;
  sb_t         exp_e;

  function automatic logic is_mem(input logic [31:0] inst);
    return (inst[6:0] == 7'b0000011) || (inst[6:0] == 7'b0100011);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle. The model is evaluated with this cycle's inputs,
  // the edge is taken, and the registered outputs are compared.
  task automatic tick();
    logic m_ready;
    logic m_disp;
    logic m_acc;
    logic mem;
    #1;
    m_ready = rst_in && rdy_in && m_run && (mq.size() != 4) && !clear;
    check("if_ready", 64'(if_ready), 64'(m_ready));
    mem    = 1'b0;
    m_disp = 1'b0;
    if (mq.size() != 0) begin
      mem    = is_mem(mq[0].inst);
      m_disp = m_run && rdy_in && !clear && rob_has_space &&
               (mem ? lsb_has_space : rs_has_space);
    end
    if (m_disp) sb.push_back({mq[0].pc, mq[0].inst, rob_tag, mem});
    m_acc = m_ready && if_valid;
    if (rdy_in && m_run && (mq.size() != 0) && !m_disp && (m_stall != 16'hFFFF))
      m_stall = m_stall + 16'd1;
    if (clear) begin
      mq.delete();
      m_run = 1'b0;
    end else if (rdy_in) begin
      if (m_disp) void'(mq.pop_front());
      if (m_acc) mq.push_back({if_pc, if_inst});
      m_run = 1'b1;
    end
    @(posedge clk_in);
    #1;
    cyc++;
    check("dec_valid", 64'(dec_valid), 64'(m_disp));
    check("rob_alloc", 64'(rob_alloc), 64'(m_disp));
    if (m_disp) begin
      exp_e = sb.pop_front();
      check("dec_pc", 64'(dec_pc), 64'(exp_e.pc));
      check("dec_inst", 64'(dec_inst), 64'(exp_e.inst));
      check("dec_tag", 64'(dec_tag), 64'(exp_e.tag));
      check("dec_to_lsb", 64'(dec_to_lsb), 64'(exp_e.lsb));
      disp_pc.push_back(dec_pc);
      disp_cyc.push_back(cyc);
    end
    check("stall_cnt", 64'(stall_cnt), 64'(m_stall));
    $display("cyc=%0d if_ready=%0b acc=%0b dec_valid=%0b dec_pc=%h dec_tag=%0h lsb=%0b stall=%0d",
             cyc, m_ready, m_acc, dec_valid, dec_pc, dec_tag, dec_to_lsb, stall_cnt);
    if (m_acc) begin
      acc_cyc.push_back(cyc);
      if_pc = if_pc + 32'd4;
    end
    rob_tag = rob_tag + 4'd1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   a0;
    int   l0;
    logic [31:0] p0;
    logic [15:0] st0;
    logic found;

    n_checks = 0; n_errors = 0; cyc = 0;
    m_run = 1'b1; m_stall = '0;
    rst_in = 1'b0; rdy_in = 1'b1; clear = 1'b0;
    if_valid = 1'b0; if_pc = 32'h0000_1000; if_inst = ADD_INST;
    rob_tag = 4'h3; rob_has_space = 1'b1; rs_has_space = 1'b1; lsb_has_space = 1'b1;

    // Reset state
    #22;
    check("rst_dec_valid", 64'(dec_valid), 64'd0);
    check("rst_rob_alloc", 64'(rob_alloc), 64'd0);
    check("rst_stall_cnt", 64'(stall_cnt), 64'd0);
    check("rst_if_ready", 64'(if_ready), 64'd0);
    check("rst_dec_pc", 64'(dec_pc), 64'd0);
    rst_in = 1'b1;

    // 1: stream of 6 ADDs
    a0 = acc_cyc.size(); l0 = disp_pc.size();
    if_valid = 1'b1; if_inst = ADD_INST;
    for (int i = 0; i < 20 && acc_cyc.size() < a0 + 6; i++) tick();
    if_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("t1_accepts", 64'(acc_cyc.size() - a0), 64'd6);
    check("t1_dispatches", 64'(disp_pc.size() - l0), 64'd6);
    if (disp_cyc.size() >= l0 + 6 && acc_cyc.size() >= a0 + 1) begin
      // accept edge followed by the dec_valid edge: one edge apart
      check("t1_latency", 64'(disp_cyc[l0] - acc_cyc[a0]), 64'd1);
      check("t1_back_to_back", 64'(disp_cyc[l0+5] - disp_cyc[l0]), 64'd5);
    end

    // 2: ROB full, offer 5, 4 accepted
    rob_has_space = 1'b0; if_valid = 1'b1; if_inst = ADD_INST;
    a0 = acc_cyc.size(); l0 = disp_pc.size(); p0 = if_pc; st0 = m_stall;
    for (int i = 0; i < 5; i++) tick();
    check("t2_accepts", 64'(acc_cyc.size() - a0), 64'd4);
    check("t2_if_ready_full", 64'(if_ready), 64'd0);
    check("t2_stall_growth", 64'(stall_cnt), 64'(st0 + 16'd4));
    if_valid = 1'b0; rob_has_space = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    check("t2_drained", 64'(disp_pc.size() - l0), 64'd4);
    for (int i = 0; i < 4; i++)
      if (disp_pc.size() > l0 + i)
        check("t2_order", 64'(disp_pc[l0+i]), 64'(p0 + 32'(4*i)));

    // 3: LW at head blocked on LSB, ADD behind it
    lsb_has_space = 1'b0; rs_has_space = 1'b1; rob_has_space = 1'b1;
    l0 = disp_pc.size();
    if_valid = 1'b1; if_inst = LW_INST; tick();
    if_inst = ADD_INST; tick();
    if_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("t3_blocked", 64'(disp_pc.size() - l0), 64'd0);
    lsb_has_space = 1'b1; tick();
    check("t3_lw_valid", 64'(dec_valid), 64'd1);
    check("t3_lw_inst", 64'(dec_inst), 64'(LW_INST));
    check("t3_lw_to_lsb", 64'(dec_to_lsb), 64'd1);
    tick();
    check("t3_add_inst", 64'(dec_inst), 64'(ADD_INST));
    check("t3_add_to_rs", 64'(dec_to_lsb), 64'd0);

    // 4: clear with 3 queued and a fetch offered
    rob_has_space = 1'b0; if_valid = 1'b1; if_inst = ADD_INST;
    for (int i = 0; i < 3; i++) tick();
    l0 = disp_pc.size();
    clear = 1'b1; if_pc = DROP_PC; tick();
    clear = 1'b0; if_valid = 1'b0; if_pc = 32'h0000_2000;
    check("t4_flush_if_ready", 64'(if_ready), 64'd0);
    check("t4_flush_dec_valid", 64'(dec_valid), 64'd0);
    tick();
    check("t4_run_if_ready", 64'(if_ready), 64'd1);
    rob_has_space = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("t4_no_dispatch", 64'(disp_pc.size() - l0), 64'd0);
    found = 1'b0;
    foreach (disp_pc[i]) if (disp_pc[i] == DROP_PC) found = 1'b1;
    check("t4_dropped_fetch", 64'(found), 64'd0);

    // 5: pause with rdy_in=0 mid-stream
    a0 = acc_cyc.size(); l0 = disp_pc.size(); p0 = if_pc;
    if_valid = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    rdy_in = 1'b0; st0 = m_stall;
    a0 = a0; // keep start index for the order check below
    for (int i = 0; i < 3; i++) tick();
    check("t5_paused_valid", 64'(dec_valid), 64'd0);
    check("t5_paused_stall", 64'(stall_cnt), 64'(st0));
    rdy_in = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    if_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("t5_count", 64'(disp_pc.size() - l0), 64'(acc_cyc.size() - a0));
    for (int i = 0; i < disp_pc.size() - l0; i++)
      check("t5_order", 64'(disp_pc[l0+i]), 64'(p0 + 32'(4*i)));

    // 6: reset between edges with a full queue
    rob_has_space = 1'b0; if_valid = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    if_valid = 1'b0; rob_has_space = 1'b1;
    tick();
    #3 rst_in = 1'b0;
    #1;
    check("t6_rst_dec_valid", 64'(dec_valid), 64'd0);
    check("t6_rst_rob_alloc", 64'(rob_alloc), 64'd0);
    check("t6_rst_stall_cnt", 64'(stall_cnt), 64'd0);
    check("t6_rst_if_ready", 64'(if_ready), 64'd0);
    mq.delete(); sb.delete(); m_stall = '0; m_run = 1'b1;
    #2 rst_in = 1'b1;
    #1;
    check("t6_release_if_ready", 64'(if_ready), 64'd1);
    l0 = disp_pc.size();
    for (int i = 0; i < 3; i++) tick();
    check("t6_no_stale_dispatch", 64'(disp_pc.size() - l0), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
